fb_stream_axi_writer: RTL and testbench

//  Downstream of the internal framebuffer command handler: consumes its address command (avalid/aaddr/abytes)
//  and its commit AXI stream, and writes the pixel data to external memory over an AXI4 write-only master.

---
 rtl/fb_stream_axi_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_fb_stream_axi_writer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_stream_axi_writer.sv
// Framebuffer stream to AXI4 write master: splits each commanded transfer into INCR bursts
// that never cross a 4 KiB page, with one burst in flight and W data passed straight from the stream.
module fb_stream_axi_writer #(
    parameter int STREAM_WIDTH  = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                      aclk,
    input  logic                      resetn,
    input  logic                      s_avalid,
    output logic                      s_aready,
    input  logic [ADDR_WIDTH-1:0]     s_aaddr,
    input  logic [ADDR_WIDTH-1:0]     s_abytes,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic [STREAM_WIDTH-1:0]   s_axis_tdata,
    input  logic [STREAM_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                      s_axis_tlast,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    output logic [STREAM_WIDTH-1:0]   m_axi_wdata,
    output logic [STREAM_WIDTH/8-1:0] m_axi_wstrb,
    output logic                      m_axi_wlast,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    input  logic [1:0]                m_axi_bresp,
    output logic                      busy,
    output logic                      errResp,
    output logic                      errStream
);

    localparam int STRB_WIDTH = STREAM_WIDTH / 8;
    localparam int SH         = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN_A = ADDR_WIDTH'(MAX_BURST_LEN);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_DRAIN = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] rem_q, rem_d;
    logic [8:0]            len_q, len_d;
    logic [8:0]            beat_q, beat_d;
    logic                  zfill_q, zfill_d;
    logic                  miss_q, miss_d;
    logic                  busy_q, busy_d;
    logic                  err_resp_q, err_resp_d;
    logic                  err_stream_q, err_stream_d;
    logic                  aready_q, awvalid_q, bready_q;

    logic                  accept_s, w_hs_s, last_beat_s, final_beat_s;
    logic [8:0]            len_m1_s;
    logic [ADDR_WIDTH-1:0] beats_s, cap_s, cand_s;
    logic [12:0]           room_bytes_s, room_beats_s;
    logic                  unused_s;

    assign accept_s     = s_avalid && aready_q;
    assign len_m1_s     = len_q - 9'd1;
    assign last_beat_s  = (beat_q == len_m1_s);
    // The final counted beat of the whole transfer is the last beat of the burst that empties rem_q.
    assign final_beat_s = last_beat_s && (rem_q == ADDR_WIDTH'(len_q));
    assign beats_s      = (s_abytes >> SH) + ADDR_WIDTH'(|s_abytes[SH-1:0]);
    assign room_bytes_s = 13'h1000 - {1'b0, addr_q[11:0]};
    assign room_beats_s = room_bytes_s >> SH;
    assign cap_s        = (rem_q < MAX_LEN_A) ? rem_q : MAX_LEN_A;
    assign cand_s       = (ADDR_WIDTH'(room_beats_s) < cap_s) ? ADDR_WIDTH'(room_beats_s) : cap_s;
    assign unused_s     = ^{s_aaddr[SH-1:0], cand_s[ADDR_WIDTH-1:9], len_m1_s[8]};

    // After an early tlast the remaining beats are written with zero strobes and the stream is left alone.
    assign m_axi_wvalid  = (state_q == S_DATA) && (zfill_q || s_axis_tvalid);
    assign s_axis_tready = ((state_q == S_DATA) && !zfill_q && m_axi_wready) || (state_q == S_DRAIN);
    assign m_axi_wdata   = ((state_q == S_DATA) && !zfill_q) ? s_axis_tdata : {STREAM_WIDTH{1'b0}};
    assign m_axi_wstrb   = ((state_q == S_DATA) && !zfill_q) ? s_axis_tstrb : {STRB_WIDTH{1'b0}};
    assign m_axi_wlast   = (state_q == S_DATA) && last_beat_s;
    assign w_hs_s        = m_axi_wvalid && m_axi_wready;

    assign s_aready      = aready_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_m1_s[7:0];
    assign m_axi_awsize  = 3'(SH);
    assign m_axi_awburst = 2'b01;
    assign m_axi_bready  = bready_q;
    assign busy          = busy_q;
    assign errResp       = err_resp_q;
    assign errStream     = err_stream_q;

    // Transfer sequencing: command latch, burst sizing, beat counting and response bookkeeping.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        len_d        = len_q;
        beat_d       = beat_q;
        zfill_d      = zfill_q;
        miss_d       = miss_q;
        busy_d       = busy_q;
        err_resp_d   = err_resp_q;
        err_stream_d = err_stream_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    addr_d       = {s_aaddr[ADDR_WIDTH-1:SH], {SH{1'b0}}};
                    rem_d        = beats_s;
                    busy_d       = 1'b1;
                    err_resp_d   = 1'b0;
                    err_stream_d = 1'b0;
                    zfill_d      = 1'b0;
                    miss_d       = 1'b0;
                    state_d      = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (rem_q == {ADDR_WIDTH{1'b0}}) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    len_d   = cand_s[8:0];
                    beat_d  = 9'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_axi_awready) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (w_hs_s) begin
                    beat_d = beat_q + 9'd1;
                    if (!zfill_q && s_axis_tlast && !final_beat_s) begin
                        zfill_d      = 1'b1;
                        err_stream_d = 1'b1;
                    end else if (!zfill_q && !s_axis_tlast && final_beat_s) begin
                        miss_d       = 1'b1;
                        err_stream_d = 1'b1;
                    end else begin
                        zfill_d = zfill_q;
                    end
                    if (last_beat_s) begin
                        beat_d  = 9'd0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                if (m_axi_bvalid) begin
                    err_resp_d = err_resp_q | (m_axi_bresp != 2'b00);
                    addr_d     = addr_q + (ADDR_WIDTH'(len_q) << SH);
                    rem_d      = rem_q - ADDR_WIDTH'(len_q);
                    if (rem_q == ADDR_WIDTH'(len_q)) begin
                        busy_d  = 1'b0;
                        state_d = miss_q ? S_DRAIN : S_IDLE;
                    end else begin
                        state_d = S_CALC;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            S_DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; handshake outputs are registered from the next state so they track it exactly.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            rem_q        <= {ADDR_WIDTH{1'b0}};
            len_q        <= 9'd1;
            beat_q       <= 9'd0;
            zfill_q      <= 1'b0;
            miss_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_resp_q   <= 1'b0;
            err_stream_q <= 1'b0;
            aready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            zfill_q      <= zfill_d;
            miss_q       <= miss_d;
            busy_q       <= busy_d;
            err_resp_q   <= err_resp_d;
            err_stream_q <= err_stream_d;
            aready_q     <= (state_d == S_IDLE);
            awvalid_q    <= (state_d == S_ADDR);
            bready_q     <= (state_d == S_RESP);
        end
    end

endmodule

// File: tb/tb_fb_stream_axi_writer.sv
// Bench for fb_stream_axi_writer: table of transfers with expected bursts, AXI slave with random
// backpressure, and queue scoreboards for AW and W; hand sequences for reset and zero-length commands.
module tb_fb_stream_axi_writer;

    logic        aclk = 1'b0;
    logic        resetn;
    logic        s_avalid, s_aready;
    logic [31:0] s_aaddr, s_abytes;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tstrb;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic [63:0] m_axi_wdata;
    logic [7:0]  m_axi_wstrb;
    logic        m_axi_bvalid, m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        busy, errResp, errStream;

    always #5 aclk = ~aclk;

    fb_stream_axi_writer #(.STREAM_WIDTH(64), .ADDR_WIDTH(32), .MAX_BURST_LEN(16)) dut (
        .aclk(aclk), .resetn(resetn),
        .s_avalid(s_avalid), .s_aready(s_aready), .s_aaddr(s_aaddr), .s_abytes(s_abytes),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tstrb(s_axis_tstrb), .s_axis_tlast(s_axis_tlast),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
        .busy(busy), .errResp(errResp), .errStream(errStream)
    );

    typedef struct packed { logic [31:0] a; logic [7:0] l; } awexp_t;
    typedef struct packed { logic [63:0] d; logic [7:0] s; logic l; } wexp_t;
    typedef struct {
        logic [31:0]       addr;
        logic [31:0]       bytes;
        int                tl;
        int                nb;
        logic [3:0][31:0]  aa;
        logic [3:0][7:0]   al;
        bit                slverr;
        bit                exp_er;
        bit                exp_es;
    } vec_t;

    awexp_t      awq[$];
    wexp_t       wq[$];
    logic [63:0] sd[$];
    logic [7:0]  ss[$];
    int          errors = 0;
    int          checks = 0;
    bit          slverr_next = 1'b0;
    vec_t        vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [31:0] addr, input logic [31:0] bytes, input int tl,
                                 input int nb, input logic [31:0] a0, input logic [7:0] l0,
                                 input logic [31:0] a1, input logic [7:0] l1,
                                 input bit slverr, input bit er, input bit es);
        vec_t v;
        v.addr = addr; v.bytes = bytes; v.tl = tl; v.nb = nb;
        v.aa = '{32'h0, 32'h0, a1, a0};
        v.al = '{8'd0, 8'd0, l1, l0};
        v.slverr = slverr; v.exp_er = er; v.exp_es = es;
        return v;
    endfunction

    // AXI slave: random ready, scoreboard comparison of AW/W, single-burst B responder.
    initial begin : slave
        bit b_pend;
        bit b_done;
        awexp_t ea;
        wexp_t  ew;
        b_pend = 1'b0; b_done = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
        forever begin
            @(negedge aclk);
            if (resetn) begin
                if (m_axi_awvalid && m_axi_awready) begin
                    if (awq.size() == 0) begin
                        chk("aw_unexpected", {32'h0, m_axi_awaddr}, 64'h0);
                    end else begin
                        ea = awq.pop_front();
                        chk("awaddr", {32'h0, m_axi_awaddr}, {32'h0, ea.a});
                        chk("awlen", {56'h0, m_axi_awlen}, {56'h0, ea.l});
                        chk("awsize", {61'h0, m_axi_awsize}, 64'd3);
                        chk("awburst", {62'h0, m_axi_awburst}, 64'd1);
                    end
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (wq.size() == 0) begin
                        chk("w_unexpected", m_axi_wdata, 64'h0);
                    end else begin
                        ew = wq.pop_front();
                        chk("wdata", m_axi_wdata, ew.d);
                        chk("wstrb", {56'h0, m_axi_wstrb}, {56'h0, ew.s});
                        chk("wlast", {63'h0, m_axi_wlast}, {63'h0, ew.l});
                    end
                    if (m_axi_wlast) b_pend = 1'b1;
                end
                if (m_axi_bvalid && m_axi_bready) b_done = 1'b1;
            end
            @(posedge aclk);
            #1;
            m_axi_awready = ($urandom_range(0, 1) == 1);
            m_axi_wready  = ($urandom_range(0, 1) == 1);
            if (b_done) begin
                m_axi_bvalid = 1'b0;
                b_done = 1'b0;
            end else if (b_pend && !m_axi_bvalid && $urandom_range(0, 2) == 0) begin
                m_axi_bvalid = 1'b1;
                m_axi_bresp  = slverr_next ? 2'b10 : 2'b00;
                slverr_next  = 1'b0;
                b_pend       = 1'b0;
            end
            if (!resetn) begin
                m_axi_bvalid = 1'b0;
                b_pend = 1'b0;
                b_done = 1'b0;
            end
        end
    end

    task automatic send_cmd(input logic [31:0] addr, input logic [31:0] bytes);
        bit got;
        got = 1'b0;
        s_aaddr = addr; s_abytes = bytes; s_avalid = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge aclk);
            got = s_aready;
            @(posedge aclk);
            #1;
        end
        s_avalid = 1'b0;
        if (!got) chk("cmd_timeout", 64'd0, 64'd1);
    endtask

    // Feeds beats [0, n) from sd/ss with tlast on beat tl-1; tvalid is held once raised.
    task automatic feed(input int n, input int tl);
        bit got;
        for (int i = 0; i < n; i++) begin
            s_axis_tdata = sd[i]; s_axis_tstrb = ss[i]; s_axis_tlast = (i == tl - 1);
            s_axis_tvalid = ($urandom_range(0, 1) == 1);
            got = 1'b0;
            for (int c = 0; c < 400 && !got; c++) begin
                @(negedge aclk);
                got = s_axis_tvalid && s_axis_tready;
                @(posedge aclk);
                #1;
                if (!got && !s_axis_tvalid) s_axis_tvalid = ($urandom_range(0, 1) == 1);
            end
            if (!got) begin
                chk("stream_timeout", 64'd0, 64'd1);
                break;
            end
        end
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 3000 && busy; c++) begin @(posedge aclk); #1; end
        chk("busy_drop", {63'h0, busy}, 64'd0);
        for (int c = 0; c < 3000 && !s_aready; c++) begin @(posedge aclk); #1; end
        chk("aready_back", {63'h0, s_aready}, 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int    idx;
        wexp_t e;
        sd.delete(); ss.delete();
        for (int i = 0; i < 64; i++) begin
            sd.push_back({$urandom, $urandom});
            ss.push_back(8'($urandom));
        end
        idx = 0;
        for (int b = 0; b < v.nb; b++) begin
            awq.push_back('{a: v.aa[b], l: v.al[b]});
            for (int j = 0; j <= int'(v.al[b]); j++) begin
                e.d = (idx < v.tl) ? sd[idx] : 64'h0;
                e.s = (idx < v.tl) ? ss[idx] : 8'h0;
                e.l = (j == int'(v.al[b]));
                wq.push_back(e);
                idx++;
            end
        end
        slverr_next = v.slverr;
        send_cmd(v.addr, v.bytes);
        chk($sformatf("v%0d_busy_on_accept", k), {63'h0, busy}, 64'd1);
        chk($sformatf("v%0d_errresp_cleared", k), {63'h0, errResp}, 64'd0);
        chk($sformatf("v%0d_errstream_cleared", k), {63'h0, errStream}, 64'd0);
        feed(v.tl, v.tl);
        wait_idle();
        chk($sformatf("v%0d_errResp", k), {63'h0, errResp}, {63'h0, v.exp_er});
        chk($sformatf("v%0d_errStream", k), {63'h0, errStream}, {63'h0, v.exp_es});
        chk($sformatf("v%0d_aw_left", k), 64'(awq.size()), 64'd0);
        chk($sformatf("v%0d_w_left", k), 64'(wq.size()), 64'd0);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        resetn = 1'b0; s_avalid = 1'b0; s_aaddr = 32'h0; s_abytes = 32'h0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 64'h0; s_axis_tstrb = 8'h0; s_axis_tlast = 1'b0;

        vecs[0] = mkv(32'h1000, 32'd256, 32, 2, 32'h1000, 8'd15, 32'h1080, 8'd15, 1'b1, 1'b1, 1'b0);
        vecs[1] = mkv(32'h1FC0, 32'd128, 16, 2, 32'h1FC0, 8'd7, 32'h2000, 8'd7, 1'b0, 1'b0, 1'b0);
        vecs[2] = mkv(32'h0204, 32'd20, 3, 1, 32'h0200, 8'd2, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);
        vecs[3] = mkv(32'h0FF8, 32'd16, 2, 2, 32'h0FF8, 8'd0, 32'h1000, 8'd0, 1'b0, 1'b0, 1'b0);
        vecs[4] = mkv(32'h0000, 32'd160, 20, 2, 32'h0000, 8'd15, 32'h0080, 8'd3, 1'b0, 1'b0, 1'b0);
        vecs[5] = mkv(32'h8000, 32'd512, 64, 4, 32'h8000, 8'd15, 32'h8080, 8'd15, 1'b0, 1'b0, 1'b0);
        vecs[5].aa[2] = 32'h8100; vecs[5].al[2] = 8'd15;
        vecs[5].aa[3] = 32'h8180; vecs[5].al[3] = 8'd15;
        vecs[6] = mkv(32'h4000, 32'd64, 5, 1, 32'h4000, 8'd7, 32'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        vecs[7] = mkv(32'h3000, 32'd24, 5, 1, 32'h3000, 8'd2, 32'h0, 8'd0, 1'b0, 1'b0, 1'b1);
        vecs[8] = mkv(32'h0100, 32'd8, 1, 1, 32'h0100, 8'd0, 32'h0, 8'd0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge aclk);
        #1;
        chk("rst_aready", {63'h0, s_aready}, 64'd0);
        chk("rst_awvalid", {63'h0, m_axi_awvalid}, 64'd0);
        chk("rst_wvalid", {63'h0, m_axi_wvalid}, 64'd0);
        chk("rst_bready", {63'h0, m_axi_bready}, 64'd0);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_errs", {62'h0, errResp, errStream}, 64'd0);
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rst_aready_after", {63'h0, s_aready}, 64'd1);

        for (int k = 0; k < 9; k++) run_vec(vecs[k], k);

        // Zero-length command: consumed, one busy cycle, no AXI traffic.
        send_cmd(32'h2000, 32'd0);
        chk("zero_busy_pulse", {63'h0, busy}, 64'd1);
        chk("zero_aready_low", {63'h0, s_aready}, 64'd0);
        @(posedge aclk);
        #1;
        chk("zero_busy_end", {63'h0, busy}, 64'd0);
        chk("zero_aready_back", {63'h0, s_aready}, 64'd1);
        repeat (4) @(posedge aclk);
        #1;
        chk("zero_no_aw", {63'h0, m_axi_awvalid}, 64'd0);

        // Reset in the middle of a data burst abandons the transfer.
        sd.delete(); ss.delete();
        for (int i = 0; i < 16; i++) begin
            sd.push_back({$urandom, $urandom});
            ss.push_back(8'hFF);
            wq.push_back('{d: sd[i], s: 8'hFF, l: (i == 15)});
        end
        awq.push_back('{a: 32'h5000, l: 8'd15});
        send_cmd(32'h5000, 32'd128);
        feed(4, 16);
        s_axis_tvalid = 1'b1; s_axis_tdata = sd[4]; s_axis_tstrb = ss[4];
        resetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("mid_rst_awvalid", {63'h0, m_axi_awvalid}, 64'd0);
        chk("mid_rst_wvalid", {63'h0, m_axi_wvalid}, 64'd0);
        chk("mid_rst_tready", {63'h0, s_axis_tready}, 64'd0);
        chk("mid_rst_bready", {63'h0, m_axi_bready}, 64'd0);
        chk("mid_rst_busy", {63'h0, busy}, 64'd0);
        s_axis_tvalid = 1'b0;
        awq.delete(); wq.delete();
        @(posedge aclk);
        #1;
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("mid_rst_aready_back", {63'h0, s_aready}, 64'd1);

        run_vec(vecs[2], 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
